// File: rtl/sensor_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_scan_pkg
// Purpose  : Shared state encoding, channel constants and helpers for the
//            three-channel sensor scan controller.
// Revision : 1.0
// ============================================================================
package sensor_scan_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_CONVERT = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    localparam logic [1:0] CH_SOIL  = 2'd0;
    localparam logic [1:0] CH_DHT11 = 2'd1;
    localparam logic [1:0] CH_RAIN  = 2'd2;
    localparam int         NUM_CH   = 3;

    // Width that holds max(a, b) - 1, never below one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        case (ch)
            CH_SOIL:  oh = 3'b001;
            CH_DHT11: oh = 3'b010;
            CH_RAIN:  oh = 3'b100;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : sensor_scan_timer
// Purpose  : Loadable down-counter with a zero flag, shared by settle and
//            inter-scan wait timing.
// Revision : 1.0
// ============================================================================
module sensor_scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sensor_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sensor_scan_ctrl
// Purpose  : Powers soil/DHT11/rain sensors in turn, pulses the ADC enable,
//            captures results and publishes them atomically per scan.
// Revision : 1.0
// ============================================================================
module sensor_scan_ctrl
    import sensor_scan_pkg::*;
#(
    parameter int RESOLUTION    = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_PERIOD = 10000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  trigger,
    input  logic [RESOLUTION-1:0] soil_digital,
    input  logic [RESOLUTION-1:0] dht11_digital,
    input  logic [RESOLUTION-1:0] rain_digital,
    output logic [2:0]            sensor_power,
    output logic [2:0]            adc_enable,
    output logic [RESOLUTION-1:0] soil_value,
    output logic [RESOLUTION-1:0] dht11_value,
    output logic [RESOLUTION-1:0] rain_value,
    output logic                  sample_valid,
    output logic                  busy,
    output logic [15:0]           scan_count
);

    localparam int            CW              = cnt_width(SETTLE_CYCLES, SAMPLE_PERIOD);
    localparam logic [CW-1:0] c_settle_load   = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] c_period_load   = CW'(SAMPLE_PERIOD - 1);

    logic [2:0]            r_state;
    logic [1:0]            r_ch;
    logic                  r_pending;
    logic [RESOLUTION-1:0] r_soil_sh;
    logic [RESOLUTION-1:0] r_dht11_sh;
    logic [RESOLUTION-1:0] r_rain_sh;

    logic [2:0]            r_sensor_power;
    logic [2:0]            r_adc_enable;
    logic [RESOLUTION-1:0] r_soil_value;
    logic [RESOLUTION-1:0] r_dht11_value;
    logic [RESOLUTION-1:0] r_rain_value;
    logic                  r_sample_valid;
    logic                  r_busy;
    logic [15:0]           r_scan_count;

    logic [2:0]            w_state_nxt;
    logic [1:0]            w_ch_nxt;
    logic                  w_pending_nxt;
    logic                  w_tmr_load;
    logic [CW-1:0]         w_tmr_val;
    logic                  w_tmr_en;
    logic                  w_tmr_done;

    sensor_scan_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ch_nxt      = r_ch;
        w_pending_nxt = r_pending;
        w_tmr_load    = 1'b0;
        w_tmr_val     = c_settle_load;
        w_tmr_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run || trigger) begin
                    w_state_nxt = S_SETTLE;
                    w_ch_nxt    = CH_SOIL;
                    w_tmr_load  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (trigger) w_pending_nxt = 1'b1;
                if (w_tmr_done) begin
                    w_state_nxt = S_CONVERT;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            S_CONVERT: begin
                if (trigger) w_pending_nxt = 1'b1;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (trigger) w_pending_nxt = 1'b1;
                if (r_ch == CH_RAIN) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                    w_ch_nxt    = r_ch + 2'd1;
                    w_tmr_load  = 1'b1;
                end
            end
            S_DONE: begin
                // A trigger arriving in this very cycle still earns a back-to-back scan.
                if (r_pending || trigger) begin
                    w_state_nxt   = S_SETTLE;
                    w_ch_nxt      = CH_SOIL;
                    w_pending_nxt = 1'b0;
                    w_tmr_load    = 1'b1;
                end else if (run) begin
                    w_state_nxt = S_WAIT;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_period_load;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (trigger || (run && w_tmr_done)) begin
                    w_state_nxt = S_SETTLE;
                    w_ch_nxt    = CH_SOIL;
                    w_tmr_load  = 1'b1;
                end else if (!run) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ch_nxt    = CH_SOIL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ch      <= CH_SOIL;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // The ADC result for the current channel is sampled while in CAPTURE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_soil_sh  <= '0;
            r_dht11_sh <= '0;
            r_rain_sh  <= '0;
        end else if (r_state == S_CAPTURE) begin
            case (r_ch)
                CH_SOIL:  r_soil_sh  <= soil_digital;
                CH_DHT11: r_dht11_sh <= dht11_digital;
                default:  r_rain_sh  <= rain_digital;
            endcase
        end
    end

    // Outputs are registered from the current state, so published values and
    // the valid strobe move on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sensor_power <= '0;
            r_adc_enable   <= '0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_soil_value   <= '0;
            r_dht11_value  <= '0;
            r_rain_value   <= '0;
            r_scan_count   <= '0;
        end else begin
            r_sensor_power <= '0;
            r_adc_enable   <= '0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            case (r_state)
                S_SETTLE, S_CAPTURE: begin
                    r_sensor_power <= ch_onehot(r_ch);
                    r_busy         <= 1'b1;
                end
                S_CONVERT: begin
                    r_sensor_power <= ch_onehot(r_ch);
                    r_adc_enable   <= ch_onehot(r_ch);
                    r_busy         <= 1'b1;
                end
                S_DONE: begin
                    r_sample_valid <= 1'b1;
                    r_busy         <= 1'b1;
                    r_scan_count   <= r_scan_count + 16'd1;
                    r_soil_value   <= r_soil_sh;
                    r_dht11_value  <= r_dht11_sh;
                    r_rain_value   <= r_rain_sh;
                end
                default: begin
                end
            endcase
        end
    end

    assign sensor_power = r_sensor_power;
    assign adc_enable   = r_adc_enable;
    assign soil_value   = r_soil_value;
    assign dht11_value  = r_dht11_value;
    assign rain_value   = r_rain_value;
    assign sample_valid = r_sample_valid;
    assign busy         = r_busy;
    assign scan_count   = r_scan_count;

endmodule
`default_nettype wire
